imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Upstream feeder for the 64x16 shift-loaded instruction memory. Accepts a
//  byte stream from the host link over a valid/ready handshake, frames it as
//  a count header plus big-endian 16-bit words, and pulses shift_enable with
//  new_value once per assembled word. Flags completion, malformed frames and
//  mid-frame stalls.
// PARAMETERS
//  DEPTH          64    max words per frame (= IMEM depth); header limit
//  TIMEOUT_CYCLES 1024  max idle cycles between bytes inside a frame
// PORTS
//  clk           in   1   clock; all logic on posedge
//  rst           in   1   synchronous, active-high reset
//  rx_valid      in   1   host byte valid
//  rx_data       in   8   host byte
//  rx_ready      out  1   loader accepts byte this cycle (valid & ready = xfer)
//  shift_enable  out  1   one-cycle pulse: shift new_value into IMEM[0]
//  new_value     out  16  assembled word; stable while shift_enable high
//  load_busy     out  1   high from header accept until DONE/ERR
//  load_done     out  1   one-cycle pulse: frame completed cleanly
//  load_error    out  1   one-cycle pulse: frame rejected/aborted
// BEHAVIOUR
//  - Reset: state=IDLE; rx_ready=1; shift_enable=0; new_value=16'h0000;
//    load_busy=0; load_done=0; load_error=0; word/timeout counters=0.
//  - Frame: byte0 = N (word count), then N x {hi byte, lo byte}.
//  - After N shifts, word k (0-based arrival) sits at IMEM[N-1-k]; host sends
//    the program last-instruction-first.
//  - States: IDLE -> HI -> LO -> (HI | CSUM | DONE); any -> ERR; DONE/ERR -> IDLE.
//  - IDLE: header xfer with 1<=N<=DEPTH -> HI, load_busy=1, remaining=N.
//    N==0 or N>DEPTH -> ERR (byte consumed).
//  - HI: xfer latches hi byte -> LO. LO: xfer registers new_value={hi,lo};
//    shift_enable pulses the next cycle (1-cycle latency from lo-byte xfer);
//    remaining decrements; remaining==0 -> CSUM (macro on) or DONE, else HI.
//  - rx_ready=1 in IDLE/HI/LO/CSUM, 0 in DONE/ERR (one cycle each).
//  - DONE: load_done=1 one cycle, load_busy=0 -> IDLE.
//  - ERR: load_error=1 one cycle, load_busy=0 -> IDLE. Words already shifted
//    stay in IMEM; no rollback.
//  - Timeout: in HI/LO/CSUM, counter +1 per cycle without xfer, clears on xfer;
//    reaching TIMEOUT_CYCLES -> ERR. Counter inactive in IDLE.
//  - rx_valid with rx_ready=0: byte not consumed; host holds it.
//  - rst mid-frame: immediate return to reset values; no done/error pulse;
//    partial words discarded.
//  - Counters: remaining 7 bits (0..64); timeout width $clog2(TIMEOUT_CYCLES+1).
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN
//   defined: after the last word, one extra byte = XOR of every hi/lo data
//     byte (header excluded). CSUM state: xfer with match -> DONE, mismatch
//     -> ERR. Running XOR clears on header accept.
//   undefined: no CSUM state or XOR register; last lo byte -> DONE.
// TESTING
//  1. N=2, bytes 12 34 AB CD (no gaps) -> shift_enable 2 pulses, new_value
//     1234 then ABCD; load_done 1 cycle after 2nd pulse; IMEM[1]=1234, IMEM[0]=ABCD.
//  2. Header 00, then header 41 (65) -> load_error pulse each, zero shifts,
//     load_busy stays 0.
//  3. N=64, all bytes valid back-to-back -> exactly 64 pulses, load_done once,
//     rx_ready low exactly 1 cycle (DONE).
//  4. N=1, send hi byte, hold rx_valid=0 for TIMEOUT_CYCLES -> load_error,
//     no shift; next header 01 accepted normally.
//  5. rst asserted after 3rd byte of N=2 frame -> all outputs at reset values
//     next cycle; no done/error pulse; 1 shift seen only if already pulsed.
//  6. Macro on: N=1, 12 34, csum 26 -> load_done; repeat with csum 27 ->
//     load_error, word 1234 still shifted.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the 64x16 shift-loaded IMEM: count header, then big-endian words, shifted in one per pulse.
// Latency: shift_enable one cycle after the lo-byte transfer, load_done/load_error one cycle after that; rx_ready drops only in DONE/ERR.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified before DONE.
module imem_loader #(
    parameter int DEPTH          = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        shift_enable,
    output logic [15:0] new_value,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    DEPTH_B = 8'(DEPTH);
    localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT_CYCLES);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_DONE, S_ERR, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_DONE, S_ERR} state_t;
`endif

    state_t        state_q, state_d;
    logic          rx_ready_q, rx_ready_d;
    logic          shift_enable_q, shift_enable_d;
    logic [15:0]   new_value_q, new_value_d;
    logic          load_busy_q, load_busy_d;
    logic          load_done_q, load_done_d;
    logic          load_error_q, load_error_d;
    logic [7:0]    hi_q, hi_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif
    logic          xfer;
    logic          in_frame;

    always_comb begin
        state_d        = state_q;
        shift_enable_d = 1'b0;
        new_value_d    = new_value_q;
        load_busy_d    = load_busy_q;
        load_done_d    = 1'b0;
        load_error_d   = 1'b0;
        hi_d           = hi_q;
        rem_d          = rem_q;
        to_cnt_d       = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
        in_frame       = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_CSUM);
`else
        in_frame       = (state_q == S_HI) || (state_q == S_LO);
`endif
        xfer = rx_valid && rx_ready_q;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if ((rx_data == 8'd0) || (rx_data > DEPTH_B)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d     = S_HI;
                        load_busy_d = 1'b1;
                        rem_d       = rx_data[CW-1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d      = 8'h00;
`endif
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = rx_data;
                    state_d = S_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                end
            end
            S_LO: begin
                if (xfer) begin
                    new_value_d    = {hi_q, rx_data};
                    shift_enable_d = 1'b1;
                    rem_d          = rem_q - 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
                    state_d = (rem_q == CW'(1)) ? S_CSUM : S_HI;
`else
                    state_d = (rem_q == CW'(1)) ? S_DONE : S_HI;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: begin
                load_done_d = 1'b1;
                load_busy_d = 1'b0;
                rem_d       = '0;
                state_d     = S_IDLE;
            end
            S_ERR: begin
                load_error_d = 1'b1;
                load_busy_d  = 1'b0;
                rem_d        = '0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Stall watchdog: only counts while a frame is open and no byte moves.
        if (in_frame) begin
            to_cnt_d = xfer ? '0 : to_cnt_q + 1'b1;
            if (!xfer && (to_cnt_d == TO_LIM)) begin
                state_d  = S_ERR;
                to_cnt_d = '0;
            end
        end

        rx_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rx_ready_q     <= 1'b1;
            shift_enable_q <= 1'b0;
            new_value_q    <= 16'h0000;
            load_busy_q    <= 1'b0;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            hi_q           <= 8'h00;
            rem_q          <= '0;
            to_cnt_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= 8'h00;
`endif
        end else begin
            state_q        <= state_d;
            rx_ready_q     <= rx_ready_d;
            shift_enable_q <= shift_enable_d;
            new_value_q    <= new_value_d;
            load_busy_q    <= load_busy_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
            hi_q           <= hi_d;
            rem_q          <= rem_d;
            to_cnt_q       <= to_cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign rx_ready     = rx_ready_q;
    assign shift_enable = shift_enable_q;
    assign new_value    = new_value_q;
    assign load_busy    = load_busy_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame traffic against a frame-level reference model of the IMEM loader.
module tb_imem_loader;
    localparam int DEPTH = 64;
    localparam int TMO   = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        shift_enable;
    logic [15:0] new_value;
    logic        load_busy;
    logic        load_done;
    logic        load_error;

    imem_loader #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .shift_enable(shift_enable), .new_value(new_value),
        .load_busy(load_busy), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_xfer_cyc = 0;

    // Monitor state, written only by the negedge monitor.
    logic [15:0] got_q[$];
    logic [15:0] mem [DEPTH];
    int n_done = 0, n_err = 0, n_rlow = 0, n_busy = 0;
    int shift_cyc = 0, pulse_cyc = 0;

    logic [15:0] plan_w[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (shift_enable) begin
            got_q.push_back(new_value);
            shift_cyc = cyc;
            for (int i = DEPTH - 1; i > 0; i--) mem[i] = mem[i-1];
            mem[0] = new_value;
        end
        if (load_done)  begin n_done++; pulse_cyc = cyc; end
        if (load_error) begin n_err++;  pulse_cyc = cyc; end
        if (!rx_ready)  n_rlow++;
        if (load_busy)  n_busy++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok, acc;
        int n;
        acc = 0; n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!acc && n < 64) begin
            ok = rx_ready;
            tick();
            n++;
            if (ok) acc = 1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (!acc) chk("xfer_stall", 0, 1);
        last_xfer_cyc = cyc;
    endtask

    // Sends one frame and checks it against the frame rules.
    task automatic run_frame(input int n, input bit bad_csum, input int gap_max);
        logic [15:0] w[$];
        logic [7:0]  cs;
        bit hdr_ok, exp_done;
        int s_words, s_done, s_err, s_rlow, s_busy, lo_cyc, nw;
        hdr_ok = (n >= 1) && (n <= DEPTH);
        s_words = got_q.size(); s_done = n_done; s_err = n_err;
        s_rlow = n_rlow; s_busy = n_busy;
        cs = 8'h00; lo_cyc = 0;
        send_byte(8'(n));
        if (hdr_ok) begin
            for (int k = 0; k < n; k++) begin
                w.push_back((plan_w.size() > k) ? plan_w[k] : 16'($urandom));
                idle($urandom_range(0, gap_max));
                send_byte(w[k][15:8]);
                idle($urandom_range(0, gap_max));
                send_byte(w[k][7:0]);
                lo_cyc = last_xfer_cyc;
                cs = cs ^ w[k][15:8] ^ w[k][7:0];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            idle($urandom_range(0, gap_max));
            send_byte(bad_csum ? (cs ^ 8'h01) : cs);
`endif
        end
        plan_w.delete();
        idle(4);
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_done = hdr_ok && !bad_csum;
`else
        exp_done = hdr_ok;
`endif
        nw = hdr_ok ? n : 0;
        chk("nwords", got_q.size() - s_words, nw);
        for (int k = 0; k < nw && (s_words + k) < got_q.size(); k++)
            chk("word", got_q[s_words + k], w[k]);
        if (hdr_ok) begin
            chk("shift_lat", shift_cyc, lo_cyc);
            for (int k = 0; k < nw; k++) chk("imem", mem[nw - 1 - k], w[k]);
        end
        chk("done_cnt", n_done - s_done, exp_done ? 1 : 0);
        chk("err_cnt", n_err - s_err, exp_done ? 0 : 1);
        chk("pulse_lat", pulse_cyc, last_xfer_cyc + 1);
        chk("rdy_low", n_rlow - s_rlow, 1);
        chk("busy_seen", (n_busy - s_busy) > 0, hdr_ok);
        chk("busy_end", load_busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s_words, s_done, s_err, s_busy, hi_cyc, n;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        idle(3);
        chk("rst_rdy", rx_ready, 1);
        chk("rst_shift", shift_enable, 0);
        chk("rst_val", new_value, 16'h0000);
        chk("rst_busy", load_busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_error, 0);
        rst = 1'b0;
        idle(2);

        // Two back-to-back words.
        plan_w.push_back(16'h1234); plan_w.push_back(16'hABCD);
        run_frame(2, 0, 0);
        // Bad headers.
        run_frame(0, 0, 0);
        run_frame(65, 0, 2);
        run_frame(255, 0, 0);
        // Full-depth frame, no gaps.
        run_frame(DEPTH, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        plan_w.push_back(16'h1234);
        run_frame(1, 0, 0);
        plan_w.push_back(16'h1234);
        run_frame(1, 1, 0);
`endif

        // Stall inside a frame after the hi byte.
        s_words = got_q.size(); s_err = n_err; s_done = n_done;
        send_byte(8'h01);
        send_byte(8'h5A);
        hi_cyc = last_xfer_cyc;
        idle(TMO + 6);
        chk("tmo_err", n_err - s_err, 1);
        chk("tmo_done", n_done - s_done, 0);
        chk("tmo_shift", got_q.size() - s_words, 0);
        chk("tmo_lat_lo", (pulse_cyc - hi_cyc) >= TMO, 1);
        chk("tmo_lat_hi", (pulse_cyc - hi_cyc) <= TMO + 2, 1);
        chk("tmo_busy", load_busy, 0);
        run_frame(1, 0, 1);

        // A gap just under the limit must not abort.
        s_words = got_q.size(); s_err = n_err; s_done = n_done;
        send_byte(8'h01);
        send_byte(8'hC3);
        idle(TMO - 2);
        send_byte(8'h3C);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hC3 ^ 8'h3C);
`endif
        idle(4);
        chk("gap_err", n_err - s_err, 0);
        chk("gap_done", n_done - s_done, 1);
        chk("gap_word", (got_q.size() > s_words) ? got_q[s_words] : 16'h0, 16'hC33C);

        // Reset right after the third byte of a two-word frame.
        s_words = got_q.size(); s_err = n_err; s_done = n_done; s_busy = n_busy;
        send_byte(8'h02);
        send_byte(8'h77);
        send_byte(8'h88);
        rst = 1'b1;
        tick();
        chk("mrst_rdy", rx_ready, 1);
        chk("mrst_shift", shift_enable, 0);
        chk("mrst_val", new_value, 16'h0000);
        chk("mrst_busy", load_busy, 0);
        rst = 1'b0;
        idle(4);
        chk("mrst_words", got_q.size() - s_words, 1);
        chk("mrst_done", n_done - s_done, 0);
        chk("mrst_err", n_err - s_err, 0);
        run_frame(3, 0, 1);

        // Randomized mix of frames.
        for (int f = 0; f < 24; f++) begin
            case ($urandom_range(0, 7))
                0:       n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 255);
                1:       n = DEPTH;
                default: n = $urandom_range(1, 16);
            endcase
            run_frame(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
